// File: rtl/io_ctrl_n.sv
// Parametrised I/O port block: synchronised input ports with change-pending
// interrupt logic, a registered read mux and writable output port registers.
module io_ctrl_n #(
    parameter  int WIDTH  = 8,
    parameter  int NPORTS = 4,
    localparam int SELW   = $clog2(NPORTS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we,
    input  logic                    mask_we,
    input  logic                    re,
    input  logic [SELW-1:0]         sel_port,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic [NPORTS*WIDTH-1:0] in_p,
    output logic [NPORTS*WIDTH-1:0] out_p,
    output logic [WIDTH-1:0]        rd_data,
    output logic [NPORTS-1:0]       pending,
    output logic                    port_interrupt
);
    localparam int NSEL = 1 << SELW;

    logic [WIDTH-1:0]  s1_reg  [NPORTS];
    logic [WIDTH-1:0]  s2_reg  [NPORTS];
    logic [WIDTH-1:0]  s3_reg  [NPORTS];
    logic [WIDTH-1:0]  out_reg [NPORTS];
    logic [WIDTH-1:0]  rd_mux  [NSEL];
    logic [WIDTH-1:0]  rd_data_reg;
    logic [NPORTS-1:0] mask_reg;
    logic [NPORTS-1:0] pending_reg;
    logic [NPORTS-1:0] pending_next;
    logic [NPORTS-1:0] chg;
    logic [1:0]        wu_reg;
    logic              wu_done;

    // Warm-up window hides the reset-to-pin-level transition from change detect.
    assign wu_done = (wu_reg == 2'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            wu_reg <= 2'd3;
        end else if (!wu_done) begin
            wu_reg <= wu_reg - 2'd1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NPORTS; gi++) begin : g_port
            always_ff @(posedge clk) begin
                if (reset) begin
                    s1_reg[gi]  <= '0;
                    s2_reg[gi]  <= '0;
                    s3_reg[gi]  <= '0;
                    out_reg[gi] <= '0;
                end else begin
                    s1_reg[gi] <= in_p[gi*WIDTH +: WIDTH];
                    s2_reg[gi] <= s1_reg[gi];
                    s3_reg[gi] <= s2_reg[gi];
                    if (we && sel_port == SELW'(gi)) begin
                        out_reg[gi] <= wr_data;
                    end
                end
            end

            assign chg[gi]                    = (s2_reg[gi] != s3_reg[gi]) && wu_done;
            assign out_p[gi*WIDTH +: WIDTH]   = out_reg[gi];
        end

        // Unused select codes read as zero when NPORTS is not a power of two.
        for (gi = 0; gi < NSEL; gi++) begin : g_rd_mux
            if (gi < NPORTS) begin : g_live
                assign rd_mux[gi] = s2_reg[gi];
            end else begin : g_dead
                assign rd_mux[gi] = '0;
            end
        end
    endgenerate

    // A new change wins over an acknowledge on the same edge so no event is lost.
    always_comb begin
        pending_next = pending_reg;
        for (int k = 0; k < NPORTS; k++) begin
            if (chg[k]) begin
                pending_next[k] = 1'b1;
            end else if (re && sel_port == SELW'(k)) begin
                pending_next[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_reg <= '0;
            mask_reg    <= '0;
            rd_data_reg <= '0;
        end else begin
            pending_reg <= pending_next;
            rd_data_reg <= rd_mux[sel_port];
            if (mask_we) begin
                mask_reg <= wr_data[NPORTS-1:0];
            end
        end
    end

    assign pending        = pending_reg;
    assign rd_data        = rd_data_reg;
    assign port_interrupt = |(pending_reg & mask_reg);

endmodule

// File: tb/tb_io_ctrl_n.sv
// Bench for io_ctrl_n: directed scenarios plus randomized traffic, all checked
// against a pin-history reference model; a 3-port instance covers unused selects.
module tb_io_ctrl_n;
    localparam int NP = 4;
    localparam int W  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              we, mask_we, re;
    logic [1:0]        sel_port;
    logic [W-1:0]      wr_data;
    logic [NP*W-1:0]   in_p;
    logic [NP*W-1:0]   out_p;
    logic [W-1:0]      rd_data;
    logic [NP-1:0]     pending;
    logic              port_interrupt;

    logic              we3, mask_we3, re3;
    logic [1:0]        sel3;
    logic [W-1:0]      wr3;
    logic [3*W-1:0]    in3;
    logic [3*W-1:0]    out3;
    logic [W-1:0]      rd3;
    logic [2:0]        pend3;
    logic              irq3;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [NP*W-1:0] hist[$];
    int              cyc;
    logic [NP-1:0]   pend_m;
    logic [NP-1:0]   mask_m;
    logic [NP*W-1:0] out_m;
    logic [W-1:0]    rd_m;

    io_ctrl_n #(.WIDTH(W), .NPORTS(NP)) dut (
        .clk(clk), .reset(reset), .we(we), .mask_we(mask_we), .re(re),
        .sel_port(sel_port), .wr_data(wr_data), .in_p(in_p), .out_p(out_p),
        .rd_data(rd_data), .pending(pending), .port_interrupt(port_interrupt)
    );

    io_ctrl_n #(.WIDTH(W), .NPORTS(3)) dut3 (
        .clk(clk), .reset(reset), .we(we3), .mask_we(mask_we3), .re(re3),
        .sel_port(sel3), .wr_data(wr3), .in_p(in3), .out_p(out3),
        .rd_data(rd3), .pending(pend3), .port_interrupt(irq3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pin vector visible at the second synchroniser stage after edge n (n counted since reset).
    function automatic logic [NP*W-1:0] sync2(input int n);
        if (n >= 2) return hist[n-2];
        return '0;
    endfunction

    task automatic model_edge();
        logic [NP*W-1:0] a, b;
        logic [NP-1:0]   set_v, clr_v;
        if (reset) begin
            cyc = 0;
            hist.delete();
            pend_m = '0;
            mask_m = '0;
            out_m  = '0;
            rd_m   = '0;
        end else begin
            cyc++;
            hist.push_back(in_p);
            a = sync2(cyc - 1);
            b = sync2(cyc - 2);
            set_v = '0;
            clr_v = '0;
            for (int k = 0; k < NP; k++) begin
                if (cyc >= 4 && a[k*W +: W] != b[k*W +: W]) set_v[k] = 1'b1;
                if (re && int'(sel_port) == k) clr_v[k] = 1'b1;
            end
            pend_m = (pend_m & ~clr_v) | set_v;
            rd_m   = a[int'(sel_port)*W +: W];
            if (mask_we) mask_m = wr_data[NP-1:0];
            if (we) out_m[int'(sel_port)*W +: W] = wr_data;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("rd_data", rd_data, rd_m);
        check("pending", pending, pend_m);
        check("port_interrupt", port_interrupt, |(pend_m & mask_m));
        check("out_p", out_p, out_m);
    endtask

    initial begin
        reset = 1'b1; we = 0; mask_we = 0; re = 0; sel_port = 0; wr_data = 0;
        in_p = 32'h0000_00FF;
        we3 = 0; mask_we3 = 0; re3 = 0; sel3 = 0; wr3 = 0; in3 = 0;

        // 1: reset with a non-zero pin, no spurious events during warm-up
        tick(); tick();
        reset = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("t1_pending", pending, 4'b0000);
            check("t1_irq", port_interrupt, 1'b0);
            if (i >= 3) check("t1_rd_data", rd_data, 8'hFF);
        end

        // 2: masked-in change raises irq, read acknowledges it
        mask_we = 1; wr_data = 8'h02; tick();
        mask_we = 0;
        in_p[15:8] = 8'h5A;
        tick(); tick();
        check("t2_pending_early", pending[1], 1'b0);
        tick();
        check("t2_pending_set", pending[1], 1'b1);
        check("t2_irq_set", port_interrupt, 1'b1);
        re = 1; sel_port = 1; tick();
        re = 0;
        check("t2_pending_clr", pending[1], 1'b0);
        check("t2_irq_clr", port_interrupt, 1'b0);
        check("t2_rd_data", rd_data, 8'h5A);

        // 3: set wins over a same-edge acknowledge
        in_p[23:16] = 8'h33; tick(); tick(); tick();
        check("t3_pending_pre", pending[2], 1'b1);
        in_p[23:16] = 8'h34; tick(); tick();
        re = 1; sel_port = 2; tick();
        re = 0;
        check("t3_set_wins", pending[2], 1'b1);
        re = 1; tick();
        re = 0;
        check("t3_cleared", pending[2], 1'b0);

        // 4: pending latches while masked, unmask raises irq next cycle
        mask_we = 1; wr_data = 8'h00; tick();
        mask_we = 0;
        in_p[31:24] = 8'hC7; tick(); tick(); tick();
        check("t4_pending", pending[3], 1'b1);
        check("t4_irq_masked", port_interrupt, 1'b0);
        mask_we = 1; wr_data = 8'h08; tick();
        mask_we = 0;
        check("t4_irq_unmask", port_interrupt, 1'b1);

        // 5: output port writes
        we = 1;
        for (int p = 0; p < 4; p++) begin
            sel_port = 2'(p); wr_data = 8'(8'h11 * (p + 1)); tick();
        end
        we = 0;
        check("t5_out_all", out_p, 32'h4433_2211);
        we = 1; sel_port = 2; wr_data = 8'hC3; tick();
        we = 0;
        check("t5_out_one", out_p, 32'h44C3_2211);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            reset    = ($urandom_range(0, 59) == 0);
            we       = $urandom_range(0, 3) == 0;
            mask_we  = $urandom_range(0, 7) == 0;
            re       = $urandom_range(0, 2) == 0;
            sel_port = 2'($urandom_range(0, 3));
            wr_data  = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                int p;
                p = $urandom_range(0, NP - 1);
                in_p[p*W +: W] = 8'($urandom);
            end
            tick();
        end
        reset = 0; we = 0; mask_we = 0; re = 0;

        // 6: NPORTS=3, select code 3 is ignored for write/ack and reads zero
        we3 = 1;
        for (int p = 0; p < 3; p++) begin
            sel3 = 2'(p); wr3 = 8'(8'hA1 + p); tick();
        end
        we3 = 0;
        in3[15:8] = 8'h77; tick(); tick(); tick();
        check("t6_pend_pre", pend3, 3'b010);
        sel3 = 1; tick();
        check("t6_rd_port1", rd3, 8'h77);
        we3 = 1; re3 = 1; sel3 = 3; wr3 = 8'hFF; tick();
        we3 = 0; re3 = 0;
        check("t6_out", out3, 24'hA3A2A1);
        check("t6_pend", pend3, 3'b010);
        check("t6_rd_zero", rd3, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
